ram_sdp_pipe: RTL and testbench

//   Parametrised simple-dual-port RAM: one write port, one read port, one clock.

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_sdp_pipe_if.sv | 26 ++
 rtl/ram_pipe_dly.sv | 43 ++++
 rtl/ram_sdp_pipe.sv | 175 +++++++++++++++++
 tb/tb_ram_sdp_pipe.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared types for the simple-dual-port RAM: controller states and
// read-during-write policy encodings.
package ram_pkg;

  typedef enum logic [1:0] {
    RAM_RST   = 2'd0,
    RAM_CLEAR = 2'd1,
    RAM_RDY   = 2'd2
  } ram_state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/ram_sdp_pipe_if.sv
// Port bundle of the simple-dual-port RAM: read port, byte-enable write port
// and the ready flag. The master side is the client, the slave side the RAM.
interface ram_sdp_pipe_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_read;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_be;
  logic                wr_valid;
  logic                ready;

  modport master (
    output rd_addr, rd_read, wr_addr, wr_data, wr_be, wr_valid,
    input  rd_data, rd_valid, ready
  );

  modport slave (
    input  rd_addr, rd_read, wr_addr, wr_data, wr_be, wr_valid,
    output rd_data, rd_valid, ready
  );
endinterface

// File: rtl/ram_pipe_dly.sv
// N-stage valid+data delay line. Only the valid bits are reset; each data
// stage loads only when the stage before it is valid, so the tail holds.
module ram_pipe_dly #(
  parameter int W = 16,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_vld,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  output logic [W-1:0] o_data
);

  logic [N-1:0] r_vld;
  logic [W-1:0] r_data [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_vld;
      for (int i = 1; i < N; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_vld) begin
      r_data[0] <= i_data;
    end
    for (int i = 1; i < N; i++) begin
      if (r_vld[i-1]) begin
        r_data[i] <= r_data[i-1];
      end
    end
  end

  assign o_vld  = r_vld[N-1];
  assign o_data = r_data[N-1];

endmodule

// File: rtl/ram_sdp_pipe.sv
// Single-clock simple-dual-port RAM with byte-enable writes, a fixed-latency
// read pipeline, selectable read-during-write policy and a post-reset clear.
module ram_sdp_pipe
  import ram_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int RD_LAT   = 6,
  parameter int RDW_MODE = 0,
  parameter int CLEAR_EN = 1
) (
  input logic           clk,
  input logic           rstp,
  ram_sdp_pipe_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  if (DATA_W % 8 != 0) begin : g_chk_data_w
    $error("ram_sdp_pipe: DATA_W must be a multiple of 8");
  end
  if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_chk_rdw
    $error("ram_sdp_pipe: RDW_MODE must be 0 or 1");
  end

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_w[8*b +: 8];
      end
    end
    return res;
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];

  ram_state_t        r_state;
  logic              r_ready;
  logic [ADDR_W-1:0] r_clr_addr;

  logic [NB-1:0]     w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  logic              w_rd_acc;
  logic              w_bypass;
  logic [DATA_W-1:0] w_rd_old;
  logic [DATA_W-1:0] w_rd_word;

  logic              r_vld_p0;
  logic [DATA_W-1:0] r_data_p0;
  logic              w_vld_out;
  logic [DATA_W-1:0] w_data_out;
  logic              r_out_zero;

  // Controller: ready is registered alongside the state it reflects
  always_ff @(posedge clk) begin
    if (rstp) begin
      r_state    <= RAM_RST;
      r_ready    <= 1'b0;
      r_clr_addr <= '0;
    end else begin
      case (r_state)
        RAM_RST: begin
          r_clr_addr <= '0;
          if (CLEAR_EN != 0) begin
            r_state <= RAM_CLEAR;
            r_ready <= 1'b0;
          end else begin
            r_state <= RAM_RDY;
            r_ready <= 1'b1;
          end
        end
        RAM_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (&r_clr_addr) begin
            r_state <= RAM_RDY;
            r_ready <= 1'b1;
          end
        end
        RAM_RDY: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= RAM_RST;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Single write port shared by the clear sweep and client writes
  always_comb begin
    w_we    = '0;
    w_waddr = bus.wr_addr;
    w_wdata = bus.wr_data;
    if (r_state == RAM_CLEAR) begin
      w_we    = '1;
      w_waddr = r_clr_addr;
      w_wdata = '0;
    end else if (r_ready && bus.wr_valid) begin
      w_we = bus.wr_be;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (w_we[b]) begin
        r_mem[w_waddr][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Read stage p0: array lookup, with write-first forwarding when selected
  assign w_rd_acc  = r_ready && bus.rd_read;
  assign w_rd_old  = r_mem[bus.rd_addr];
  assign w_bypass  = (RDW_MODE == RDW_NEW) && r_ready && bus.wr_valid &&
                     (bus.rd_addr == bus.wr_addr);
  assign w_rd_word = w_bypass ? merge_bytes(w_rd_old, bus.wr_data, bus.wr_be) : w_rd_old;

  always_ff @(posedge clk) begin
    if (rstp) begin
      r_vld_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= w_rd_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd_acc) begin
      r_data_p0 <= w_rd_word;
    end
  end

  // Stages p1..: remaining RD_LAT-1 cycles of read latency
  if (RD_LAT < 1) begin : g_chk_lat
    $error("ram_sdp_pipe: RD_LAT must be >= 1");
  end else if (RD_LAT == 1) begin : g_lat1
    assign w_vld_out  = r_vld_p0;
    assign w_data_out = r_data_p0;
  end else begin : g_latn
    ram_pipe_dly #(
      .W (DATA_W),
      .N (RD_LAT - 1)
    ) u_dly (
      .clk    (clk),
      .rst    (rstp),
      .i_vld  (r_vld_p0),
      .i_data (r_data_p0),
      .o_vld  (w_vld_out),
      .o_data (w_data_out)
    );
  end

  // Output: rd_data reads zero from reset until the first result emerges
  always_ff @(posedge clk) begin
    if (rstp) begin
      r_out_zero <= 1'b1;
    end else if (w_vld_out) begin
      r_out_zero <= 1'b0;
    end
  end

  assign bus.rd_valid = w_vld_out;
  assign bus.rd_data  = (r_out_zero && !w_vld_out) ? '0 : w_data_out;
  assign bus.ready    = r_ready;

endmodule

// File: tb/tb_ram_sdp_pipe.sv
// Bench for ram_sdp_pipe: three latency/RDW variants share one random stimulus
// stream; a word-array reference model feeds per-instance expectation queues.
module tb_ram_sdp_pipe;

  localparam int NI  = 3;
  localparam int INF = 2147483647;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 6;
      1:       return 1;
      default: return 9;
    endcase
  endfunction

  function automatic int rdw_of(input int g);
    return (g == 1) ? 1 : 0;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_rst      = 1'b0;
  logic        d_rd_read  = 1'b0;
  logic [7:0]  d_rd_addr  = '0;
  logic        d_wr_valid = 1'b0;
  logic [7:0]  d_wr_addr  = '0;
  logic [15:0] d_wr_data  = '0;
  logic [1:0]  d_wr_be    = '0;

  int edge_n        = 0;
  int n_chk         = 0;
  int n_fail        = 0;
  int rst_at        = INF;
  int rdy_from      = INF;
  int chk_from      = INF;
  int last_rst_edge = INF;
  bit cur_rst       = 1'b0;

  logic [15:0] mdl [256];
  int          q_due [NI][$];
  logic [15:0] q_dat [NI][$];
  logic [15:0] last_dat [NI];

  initial forever begin
    @(posedge clk);
    edge_n++;
  end

  // Expected ready after edge k
  function automatic bit exp_ready(input int k);
    return (k >= rdy_from) && (k < rst_at);
  endfunction

  task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d edge %0d: got %h, expected %h", nm, g, edge_n, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ram_sdp_pipe_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    assign bus.rd_addr  = d_rd_addr;
    assign bus.rd_read  = d_rd_read;
    assign bus.wr_addr  = d_wr_addr;
    assign bus.wr_data  = d_wr_data;
    assign bus.wr_be    = d_wr_be;
    assign bus.wr_valid = d_wr_valid;

    ram_sdp_pipe #(
      .DATA_W   (16),
      .ADDR_W   (8),
      .RD_LAT   (lat_of(g)),
      .RDW_MODE (rdw_of(g)),
      .CLEAR_EN (1)
    ) u_dut (
      .clk  (clk),
      .rstp (d_rst),
      .bus  (bus)
    );

    initial forever begin
      bit expv;
      @(negedge clk);
      if (edge_n >= chk_from) begin
        if (edge_n == last_rst_edge) last_dat[g] = '0;
        check("ready", g, 32'(bus.ready), 32'(exp_ready(edge_n)));
        expv = (q_due[g].size() != 0) && (q_due[g][0] == edge_n);
        check("rd_valid", g, 32'(bus.rd_valid), 32'(expv));
        if (expv) begin
          if (bus.rd_valid === 1'b1) check("rd_data", g, 32'(bus.rd_data), 32'(q_dat[g][0]));
          last_dat[g] = q_dat[g][0];
          void'(q_due[g].pop_front());
          void'(q_dat[g].pop_front());
        end else begin
          check("rd_hold", g, 32'(bus.rd_data), 32'(last_dat[g]));
        end
      end
    end
  end

  // One clock of stimulus; the model decides acceptance from reset history
  task automatic step(input bit rst, input bit rd, input int ra, input bit wr,
                      input int wa, input logic [15:0] wd, input logic [1:0] be);
    int          n;
    bit          acc;
    logic [15:0] m;
    logic [15:0] old_w;
    logic [15:0] new_w;
    @(posedge clk);
    #1;
    d_rst      = rst;
    d_rd_read  = rd;
    d_rd_addr  = ra[7:0];
    d_wr_valid = wr;
    d_wr_addr  = wa[7:0];
    d_wr_data  = wd;
    d_wr_be    = be;
    n = edge_n + 1;
    if (rst && !cur_rst) begin
      rst_at        = n;
      last_rst_edge = n;
      if (chk_from == INF) chk_from = n;
      for (int i = 0; i < NI; i++) begin
        while (q_due[i].size() != 0 && q_due[i][$] >= n) begin
          void'(q_due[i].pop_back());
          void'(q_dat[i].pop_back());
        end
      end
    end else if (!rst && cur_rst) begin
      // edge n leaves reset, the next 256 edges clear the array
      rdy_from = n + 256;
      rst_at   = INF;
      foreach (mdl[i]) mdl[i] = '0;
    end
    cur_rst = rst;
    acc = exp_ready(edge_n) && !rst;
    m = {{8{be[1]}}, {8{be[0]}}};
    if (acc && rd) begin
      old_w = mdl[ra];
      new_w = (wr && wa == ra) ? ((old_w & ~m) | (wd & m)) : old_w;
      for (int i = 0; i < NI; i++) begin
        q_due[i].push_back(n + lat_of(i) - 1);
        q_dat[i].push_back(rdw_of(i) != 0 ? new_w : old_w);
      end
    end
    if (acc && wr) mdl[wa] = (mdl[wa] & ~m) | (wd & m);
  endtask

  task automatic idle(input int cnt);
    repeat (cnt) step(cur_rst, 1'b0, 0, 1'b0, 0, 16'h0, 2'b00);
  endtask

  // Leave reset and keep issuing (ignored) random traffic until ready
  task automatic release_to_ready();
    int guard = 0;
    do begin
      step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 255)), 16'($urandom), 2'b11);
      guard++;
    end while (!exp_ready(edge_n) && guard < 1000);
  endtask

  task automatic read_sweep();
    for (int a = 0; a < 256; a++) step(1'b0, 1'b1, a, 1'b0, 0, 16'h0, 2'b00);
  endtask

  initial begin
    foreach (mdl[i]) mdl[i] = '0;
    foreach (last_dat[i]) last_dat[i] = '0;

    repeat (3) step(1'b1, 1'b0, 0, 1'b0, 0, 16'h0, 2'b00);
    release_to_ready();
    read_sweep();
    idle(12);

    step(1'b0, 1'b0, 0,     1'b1, 'h10, 16'hA5C3, 2'b11);
    step(1'b0, 1'b1, 'h10,  1'b0, 0,    16'h0,    2'b00);
    step(1'b0, 1'b0, 0,     1'b1, 'h20, 16'h1234, 2'b11);
    step(1'b0, 1'b0, 0,     1'b1, 'h20, 16'hFFFF, 2'b01);
    step(1'b0, 1'b1, 'h20,  1'b0, 0,    16'h0,    2'b00);
    step(1'b0, 1'b0, 0,     1'b1, 'h30, 16'h0001, 2'b11);
    step(1'b0, 1'b1, 'h30,  1'b1, 'h30, 16'hBEEF, 2'b11);
    step(1'b0, 1'b1, 'h30,  1'b1, 'h30, 16'h5A00, 2'b10);
    step(1'b0, 1'b1, 'h30,  1'b1, 'h31, 16'h7777, 2'b00);
    step(1'b0, 1'b1, 'h10,  1'b1, 'h10, 16'h0000, 2'b00);
    idle(12);

    // Dense random traffic over a small window to force address collisions
    repeat (600) begin
      step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)));
    end
    idle(12);

    // Reset in the middle of a read burst, with reads still requested
    for (int a = 0; a < 20; a++) step(1'b0, 1'b1, a + 100, 1'b0, 0, 16'h0, 2'b00);
    repeat (3) step(1'b1, 1'b1, int'($urandom_range(0, 255)), 1'b1, int'($urandom_range(0, 255)),
                    16'($urandom), 2'b11);

    // Interrupt the clear at cycle 100 while writes are being attempted
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, int'($urandom_range(0, 255)), 1'b1, int'($urandom_range(0, 255)),
           16'($urandom), 2'b11);
    end
    repeat (2) step(1'b1, 1'b0, 0, 1'b1, 5, 16'hFFFF, 2'b11);
    release_to_ready();
    read_sweep();
    idle(12);

    for (int i = 0; i < NI; i++) check("queue_drained", i, q_due[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
